uart_prog_loader: RTL

Parametrised next-generation UART programming receiver. It contains its own 16x-oversampled RX, a framed packet parser (sync, length, payload, checksum), a byte-to-word assembler of configurable width and endianness, and a word FIFO of configurable depth. Programming words leave with an auto-incrementing address over a valid/ready write port to the memory controller. It replaces the fixed 8-in/32-out path and adds framing, overflow and checksum error reporting.

---
 rtl/uart_prog_pkg.sv | 24 ++
 rtl/uart_rx_os16.sv | 112 +++++++++++
 rtl/uart_prog_loader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/uart_prog_pkg.sv
// Shared types and constants for the UART programming loader.
// Holds the loader FSM encoding and the RX oversampling constants.
package uart_prog_pkg;

  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DRAIN
  } prog_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam int OVERSAMPLE  = 16;
  localparam int START_CHECK = 8;

endpackage

// File: rtl/uart_rx_os16.sv
// 16x oversampled UART receiver: tick generator, synchroniser,
// bit sampler, one-cycle byte strobe and stop-bit error pulse.
module uart_rx_os16
  import uart_prog_pkg::*;
#(
  parameter int CLK_DIV = 27
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       rx,
  output logic       byte_stb,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0] div_q;
  logic          tick;
  logic          meta_q, rxs_q, prev_q;
  rx_state_t     state_q, state_d;
  logic [3:0]    os_q, os_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          stb_q, stb_d;
  logic          ferr_q, ferr_d;

  assign tick      = (div_q == DW'(CLK_DIV - 1));
  assign byte_stb  = stb_q;
  assign byte_data = sh_q;
  assign frame_err = ferr_q;

  always_comb begin
    state_d = state_q;
    os_d    = os_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    stb_d   = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (prev_q && !rxs_q) begin
          state_d = RX_START;
          os_d    = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (os_q == 4'(START_CHECK - 1)) begin
            os_d    = '0;
            bit_d   = '0;
            // a line already back high mid start bit was a glitch
            state_d = rxs_q ? RX_IDLE : RX_DATA;
          end else begin
            os_d = os_q + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (os_q == 4'(OVERSAMPLE - 1)) begin
            os_d  = '0;
            sh_d  = {rxs_q, sh_q[7:1]};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = RX_STOP;
          end else begin
            os_d = os_q + 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (os_q == 4'(OVERSAMPLE - 1)) begin
            state_d = RX_IDLE;
            stb_d   = rxs_q;
            ferr_d  = !rxs_q;
          end else begin
            os_d = os_q + 4'd1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      div_q   <= '0;
      meta_q  <= 1'b1;
      rxs_q   <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      os_q    <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      stb_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      div_q   <= tick ? '0 : div_q + 1'b1;
      meta_q  <= rx;
      rxs_q   <= meta_q;
      prev_q  <= rxs_q;
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      stb_q   <= stb_d;
      ferr_q  <= ferr_d;
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// UART programming receiver: packet parser, word assembler and
// first-word-fall-through FIFO feeding an addressed write port.
module uart_prog_loader
  import uart_prog_pkg::*;
#(
  parameter int         CLK_DIV        = 27,
  parameter int         BYTES_PER_WORD = 4,
  parameter bit         LITTLE_ENDIAN  = 1'b1,
  parameter int         FIFO_DEPTH     = 8,
  parameter int         ADDR_W         = 32,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic                        clk,
  input  logic                        Rst,
  input  logic                        rx,
  output logic                        wr_valid,
  input  logic                        wr_ready,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [8*BYTES_PER_WORD-1:0] wr_data,
  output logic                        prog_active,
  output logic                        prog_done,
  output logic                        err_frame,
  output logic                        err_csum,
  output logic                        err_ovf
);

  localparam int DW = 8 * BYTES_PER_WORD;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BYTES_PER_WORD + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     data;
  } entry_t;

  logic        byte_stb;
  logic [7:0]  byte_data;
  logic        frame_err;

  prog_state_t       state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        csum_q, csum_d;
  logic [DW-1:0]     asm_q, asm_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [BW-1:0]     slot;
  logic              push_q, push_d;
  logic              done_q, done_d;
  logic              ef_q, ef_d;
  logic              ec_q, ec_d;
  logic              eo_q, eo_d;

  entry_t            mem [FIFO_DEPTH];
  logic [PW:0]       wp_q, rp_q;
  entry_t            head;
  logic              empty, full, pop, do_push, ovf;

  uart_rx_os16 #(
    .CLK_DIV(CLK_DIV)
  ) u_rx (
    .clk      (clk),
    .Rst      (Rst),
    .rx       (rx),
    .byte_stb (byte_stb),
    .byte_data(byte_data),
    .frame_err(frame_err)
  );

  assign empty   = (wp_q == rp_q);
  assign full    = (wp_q[PW] != rp_q[PW]) &&
                   (wp_q[PW-1:0] == rp_q[PW-1:0]);
  assign pop     = wr_valid && wr_ready;
  assign do_push = push_q && (!full || pop);
  assign ovf     = push_q && full && !pop;
  assign head    = mem[rp_q[PW-1:0]];

  assign wr_valid    = !empty;
  assign wr_addr     = empty ? '0 : head.addr;
  assign wr_data     = empty ? '0 : head.data;
  assign prog_active = (state_q != S_SYNC);
  assign prog_done   = done_q;
  assign err_frame   = ef_q;
  assign err_csum    = ec_q;
  assign err_ovf     = eo_q;

  assign slot = LITTLE_ENDIAN ? bcnt_q
                              : BW'(BYTES_PER_WORD - 1) - bcnt_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    csum_d  = csum_q;
    asm_d   = asm_q;
    bcnt_d  = bcnt_q;
    push_d  = 1'b0;
    done_d  = 1'b0;
    ef_d    = ef_q;
    ec_d    = ec_q;
    eo_d    = eo_q;
    if (do_push) addr_d = addr_q + ADDR_W'(BYTES_PER_WORD);
    if (ovf) eo_d = 1'b1;
    if (frame_err) begin
      ef_d    = 1'b1;
      state_d = S_SYNC;
    end else if (byte_stb) begin
      unique case (state_q)
        S_SYNC: begin
          if (byte_data == SYNC_BYTE) begin
            ef_d    = 1'b0;
            ec_d    = 1'b0;
            eo_d    = 1'b0;
            addr_d  = '0;
            csum_d  = '0;
            bcnt_d  = '0;
            state_d = S_LEN0;
          end
        end
        S_LEN0: begin
          len_d[7:0] = byte_data;
          state_d    = S_LEN1;
        end
        S_LEN1: begin
          len_d[15:8] = byte_data;
          state_d = ({byte_data, len_q[7:0]} == 16'd0) ? S_CSUM
                                                         : S_DATA;
        end
        S_DATA: begin
          csum_d = csum_q + byte_data;
          asm_d[{slot, 3'b000} +: 8] = byte_data;
          if (bcnt_q == BW'(BYTES_PER_WORD - 1)) begin
            bcnt_d = '0;
            push_d = 1'b1;
            len_d  = len_q - 16'd1;
            if (len_q == 16'd1) state_d = S_CSUM;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        S_CSUM: begin
          if (byte_data == csum_q) begin
            state_d = S_DRAIN;
          end else begin
            ec_d    = 1'b1;
            state_d = S_SYNC;
          end
        end
        S_DRAIN: ;
        default: state_d = S_SYNC;
      endcase
    end
    if (state_q == S_DRAIN && empty && !push_q) begin
      done_d  = 1'b1;
      state_d = S_SYNC;
    end
    // a dropped word leaves the image incomplete, so abandon the packet
    if (ovf) state_d = S_SYNC;
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_SYNC;
      len_q   <= '0;
      addr_q  <= '0;
      csum_q  <= '0;
      asm_q   <= '0;
      bcnt_q  <= '0;
      push_q  <= 1'b0;
      done_q  <= 1'b0;
      ef_q    <= 1'b0;
      ec_q    <= 1'b0;
      eo_q    <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      csum_q  <= csum_d;
      asm_q   <= asm_d;
      bcnt_q  <= bcnt_d;
      push_q  <= push_d;
      done_q  <= done_d;
      ef_q    <= ef_d;
      ec_q    <= ec_d;
      eo_q    <= eo_d;
      if (do_push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp_q[PW-1:0]] <= '{addr: addr_q, data: asm_q};
  end

endmodule
